// File: rtl/if_stage_bht.sv
`default_nettype none
// ============================================================================
//  Module   : if_stage_bht
//  Purpose  : Instruction-fetch stage. Holds the PC, drives the instruction
//             memory address and predicts conditional branches with a
//             PC-indexed table of 2-bit saturating counters trained from EX.
//             Also handles EX redirect, program switch, stall and a sticky
//             halt.
//  Ports    :
//    clk, rst        clock / asynchronous active-high reset
//    imem_addr       instruction-memory address (low bits of pc)
//    imem_rdata      instruction at imem_addr, valid in the same cycle
//    stall_PC        hold the PC (hazard stall)
//    changeFlow      EX redirect; load jb_addr
//    jb_addr         redirect target
//    switch_program  program switch; load SPART_pc
//    SPART_pc        new program start PC
//    upd_valid       EX resolved a conditional branch this cycle
//    upd_pc          PC of the resolved branch
//    upd_taken       resolved direction (1 = taken)
//    instr           fetched instruction (= imem_rdata)
//    pc_out          current PC
//    pc_1            pc + 1
//    pred_taken      current instruction is a branch predicted taken
//    pred_addr       pc_1 + sign-extended instr[15:0]
//    halt            halt opcode fetched or sticky halted state
//  Revision : 1.0  initial release
// ============================================================================
module if_stage_bht #(
   parameter int              PC_W        = 32,
   parameter int              IMEM_AW     = 10,
   parameter int              BHT_ENTRIES = 16,
   parameter logic [PC_W-1:0] RESET_PC    = '0
) (
   input  logic               clk,
   input  logic               rst,
   output logic [IMEM_AW-1:0] imem_addr,
   input  logic [31:0]        imem_rdata,
   input  logic               stall_PC,
   input  logic               changeFlow,
   input  logic [PC_W-1:0]    jb_addr,
   input  logic               switch_program,
   input  logic [PC_W-1:0]    SPART_pc,
   input  logic               upd_valid,
   input  logic [PC_W-1:0]    upd_pc,
   input  logic               upd_taken,
   output logic [31:0]        instr,
   output logic [PC_W-1:0]    pc_out,
   output logic [PC_W-1:0]    pc_1,
   output logic               pred_taken,
   output logic [PC_W-1:0]    pred_addr,
   output logic               halt
);

   localparam int         IDX_W      = $clog2(BHT_ENTRIES);
   localparam logic [5:0] OP_BR_LO   = 6'h13;
   localparam logic [5:0] OP_BR_HI   = 6'h19;
   localparam logic [5:0] OP_HALT    = 6'h31;
   localparam logic [1:0] CTR_RESET  = 2'b01;  // weakly not-taken

   logic [PC_W-1:0]   pc;
   logic [PC_W-1:0]   pc_next;
   logic              halted;
   logic [5:0]        opcode;
   logic              is_branch;
   logic              halt_op;
   logic signed [15:0] offset;
   logic [PC_W-1:0]   offset_ext;
   logic [IDX_W-1:0]  rd_idx;
   logic [IDX_W-1:0]  upd_idx;
   logic [1:0]        ctr [BHT_ENTRIES];
   logic              unused_bits;

   // ---------------------------------------------------------------------
   // Decode and prediction (all combinational from the current pc / instr)
   // ---------------------------------------------------------------------
   assign instr      = imem_rdata;
   assign imem_addr  = pc[IMEM_AW-1:0];
   assign pc_out     = pc;
   assign pc_1       = pc + PC_W'(1);

   assign opcode     = imem_rdata[31:26];
   assign is_branch  = (opcode >= OP_BR_LO) && (opcode <= OP_BR_HI);
   assign halt_op    = (opcode == OP_HALT);
   assign halt       = halted | halt_op;

   // Size cast of a signed value sign-extends the branch offset to PC_W.
   assign offset     = imem_rdata[15:0];
   assign offset_ext = PC_W'(offset);
   assign pred_addr  = pc_1 + offset_ext;

   // No tag: every PC with the same low index bits shares one counter.
   assign rd_idx     = pc[IDX_W-1:0];
   assign upd_idx    = upd_pc[IDX_W-1:0];
   assign pred_taken = is_branch & ctr[rd_idx][1];

   assign unused_bits = ^{imem_rdata[25:16], upd_pc};

   // ---------------------------------------------------------------------
   // Next-PC selection, highest priority first
   // ---------------------------------------------------------------------
   always_comb begin
      pc_next = pc_1;
      if (switch_program) begin
         pc_next = SPART_pc;
      end else if (changeFlow) begin
         pc_next = jb_addr;
      end else if (stall_PC || halt) begin
         pc_next = pc;
      end else if (pred_taken) begin
         pc_next = pred_addr;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc     <= RESET_PC;
         halted <= 1'b0;
      end else begin
         pc <= pc_next;
         // A redirect or switch squashes a halt fetched on the wrong path.
         if (switch_program || changeFlow) begin
            halted <= 1'b0;
         end else if (halt_op) begin
            halted <= 1'b1;
         end
      end
   end

   // ---------------------------------------------------------------------
   // Branch history table: one saturating counter per entry. Training is
   // independent of stall / halt / redirect; a same-cycle fetch of the
   // updated index sees the old value.
   // ---------------------------------------------------------------------
   for (genvar i = 0; i < BHT_ENTRIES; i++) begin : g_bht
      logic [1:0] cnt;

      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            cnt <= CTR_RESET;
         end else if (upd_valid && (upd_idx == IDX_W'(i))) begin
            if (upd_taken) begin
               if (cnt != 2'b11) cnt <= cnt + 2'b01;
            end else begin
               if (cnt != 2'b00) cnt <= cnt - 2'b01;
            end
         end
      end

      assign ctr[i] = cnt;
   end

endmodule
`default_nettype wire

// File: tb/tb_if_stage_bht.sv
`default_nettype none
// ============================================================================
//  Module   : tb_if_stage_bht
//  Purpose  : Self-checking bench for if_stage_bht. A behavioural instruction
//             memory feeds the DUT; a reference counter table tracks the
//             expected BHT state; expected PCs go through a scoreboard queue.
//  Revision : 1.0  initial release
// ============================================================================
module tb_if_stage_bht;

   localparam int PC_W    = 32;
   localparam int IMEM_AW = 10;
   localparam int N       = 16;

   logic               clk = 1'b0;
   logic               rst;
   logic [IMEM_AW-1:0] imem_addr;
   logic [31:0]        imem_rdata;
   logic               stall_PC;
   logic               changeFlow;
   logic [PC_W-1:0]    jb_addr;
   logic               switch_program;
   logic [PC_W-1:0]    SPART_pc;
   logic               upd_valid;
   logic [PC_W-1:0]    upd_pc;
   logic               upd_taken;
   logic [31:0]        instr;
   logic [PC_W-1:0]    pc_out;
   logic [PC_W-1:0]    pc_1;
   logic               pred_taken;
   logic [PC_W-1:0]    pred_addr;
   logic               halt;

   logic [31:0]        mem [0:(1<<IMEM_AW)-1];
   logic [1:0]         model [N];
   logic [PC_W-1:0]    exp_q [$];
   logic [PC_W-1:0]    exp_pc;
   int                 vectors     = 0;
   int                 miscompares = 0;

   localparam logic [31:0] HALT_INSTR = {6'h31, 26'h0};

   assign imem_rdata = mem[imem_addr];

   always #5 clk = ~clk;

   if_stage_bht #(
      .PC_W(PC_W), .IMEM_AW(IMEM_AW), .BHT_ENTRIES(N), .RESET_PC('0)
   ) dut (
      .clk(clk), .rst(rst), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
      .stall_PC(stall_PC), .changeFlow(changeFlow), .jb_addr(jb_addr),
      .switch_program(switch_program), .SPART_pc(SPART_pc),
      .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken),
      .instr(instr), .pc_out(pc_out), .pc_1(pc_1), .pred_taken(pred_taken),
      .pred_addr(pred_addr), .halt(halt)
   );

   function automatic logic [31:0] br(input logic [15:0] off);
      return {6'h13, 10'h0, off};
   endfunction

   // Advance one clock; lands 1 time unit after the falling edge.
   task automatic tick();
      @(posedge clk);
      @(negedge clk);
      #1;
   endtask

   task automatic go_to(input logic [PC_W-1:0] tgt);
      changeFlow = 1'b1;
      jb_addr    = tgt;
      tick();
      changeFlow = 1'b0;
   endtask

   // Train one index n times with the PC stalled; reference table follows.
   task automatic train(input logic [PC_W-1:0] p, input logic t, input int n);
      stall_PC  = 1'b1;
      upd_valid = 1'b1;
      upd_pc    = p;
      upd_taken = t;
      for (int k = 0; k < n; k++) begin
         tick();
         if (t && model[p[3:0]] != 2'b11) model[p[3:0]] = model[p[3:0]] + 2'b01;
         if (!t && model[p[3:0]] != 2'b00) model[p[3:0]] = model[p[3:0]] - 2'b01;
      end
      stall_PC  = 1'b0;
      upd_valid = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      @(negedge clk);
      #1;
      vectors++;
      if (pc_out !== 32'd0) begin
         miscompares++; $display("FAIL reset_pc: got %h expected %h", pc_out, 32'd0);
      end
      vectors++;
      if (pc_1 !== 32'd1) begin
         miscompares++; $display("FAIL reset_pc1: got %h expected %h", pc_1, 32'd1);
      end
      vectors++;
      if (pred_taken !== 1'b0 || halt !== 1'b0) begin
         miscompares++; $display("FAIL reset_flags: got pred=%b halt=%b expected 0 0", pred_taken, halt);
      end
      rst = 1'b0;
   endtask

   task automatic test_sequential();
      for (int i = 1; i <= 3; i++) begin
         exp_q.push_back(PC_W'(i));
         tick();
         exp_pc = exp_q.pop_front();
         vectors++;
         if (pc_out !== exp_pc || pred_taken !== 1'b0) begin
            miscompares++;
            $display("FAIL seq_pc: got %h pred=%b expected %h pred=0", pc_out, pred_taken, exp_pc);
         end
      end
   endtask

   task automatic test_branch();
      mem[4] = br(16'hFFFE);
      go_to(32'd4);
      vectors++;
      if (pred_taken !== model[4][1] || pred_addr !== 32'd3) begin
         miscompares++;
         $display("FAIL br_cold: got pred=%b addr=%h expected pred=%b addr=%h", pred_taken, pred_addr, model[4][1], 32'd3);
      end
      exp_q.push_back(32'd5);
      tick();
      exp_pc = exp_q.pop_front();
      vectors++;
      if (pc_out !== exp_pc) begin
         miscompares++; $display("FAIL br_cold_next: got %h expected %h", pc_out, exp_pc);
      end
      train(32'd4, 1'b1, 2);
      go_to(32'd4);
      vectors++;
      if (pred_taken !== 1'b1 || pred_addr !== 32'd3) begin
         miscompares++;
         $display("FAIL br_trained: got pred=%b addr=%h expected pred=1 addr=%h", pred_taken, pred_addr, 32'd3);
      end
      exp_q.push_back(32'd3);
      tick();
      exp_pc = exp_q.pop_front();
      vectors++;
      if (pc_out !== exp_pc) begin
         miscompares++; $display("FAIL br_trained_next: got %h expected %h", pc_out, exp_pc);
      end
   endtask

   task automatic test_saturate();
      // pc 18 aliases index 2, which is the index being trained.
      mem[18] = br(16'h0005);
      train(32'd2, 1'b1, 4);
      train(32'd2, 1'b0, 1);
      go_to(32'd18);
      vectors++;
      if (pred_taken !== 1'b1 || pred_addr !== 32'd24) begin
         miscompares++;
         $display("FAIL sat_pred: got pred=%b addr=%h expected pred=1 addr=%h", pred_taken, pred_addr, 32'd24);
      end
      exp_q.push_back(32'd24);
      tick();
      exp_pc = exp_q.pop_front();
      vectors++;
      if (pc_out !== exp_pc) begin
         miscompares++; $display("FAIL sat_next: got %h expected %h", pc_out, exp_pc);
      end
      // Same-cycle update of the fetched index: old counter (10) predicts.
      go_to(32'd18);
      upd_valid = 1'b1; upd_pc = 32'd2; upd_taken = 1'b0;
      #1;
      vectors++;
      if (pred_taken !== model[2][1]) begin
         miscompares++; $display("FAIL same_cycle_pred: got %b expected %b", pred_taken, model[2][1]);
      end
      exp_q.push_back(32'd24);
      tick();
      model[2] = model[2] - 2'b01;
      upd_valid = 1'b0;
      exp_pc = exp_q.pop_front();
      vectors++;
      if (pc_out !== exp_pc) begin
         miscompares++; $display("FAIL same_cycle_next: got %h expected %h", pc_out, exp_pc);
      end
      go_to(32'd18);
      vectors++;
      if (pred_taken !== model[2][1]) begin
         miscompares++; $display("FAIL after_update_pred: got %b expected %b", pred_taken, model[2][1]);
      end
      exp_q.push_back(32'd19);
      tick();
      exp_pc = exp_q.pop_front();
      vectors++;
      if (pc_out !== exp_pc) begin
         miscompares++; $display("FAIL after_update_next: got %h expected %h", pc_out, exp_pc);
      end
   endtask

   task automatic test_halt();
      mem[8] = HALT_INSTR;
      go_to(32'd8);
      vectors++;
      if (halt !== 1'b1 || pc_out !== 32'd8) begin
         miscompares++; $display("FAIL halt_fetch: got halt=%b pc=%h expected halt=1 pc=%h", halt, pc_out, 32'd8);
      end
      exp_q.push_back(32'd8);
      tick();
      exp_pc = exp_q.pop_front();
      vectors++;
      if (pc_out !== exp_pc || halt !== 1'b1) begin
         miscompares++; $display("FAIL halt_hold: got pc=%h halt=%b expected pc=%h halt=1", pc_out, halt, exp_pc);
      end
      // Remove the opcode: halt must persist from the sticky state.
      mem[8] = 32'h0;
      #1;
      exp_q.push_back(32'd8);
      tick();
      exp_pc = exp_q.pop_front();
      vectors++;
      if (pc_out !== exp_pc || halt !== 1'b1) begin
         miscompares++; $display("FAIL halt_sticky: got pc=%h halt=%b expected pc=%h halt=1", pc_out, halt, exp_pc);
      end
      go_to(32'd20);
      vectors++;
      if (pc_out !== 32'd20 || halt !== 1'b0) begin
         miscompares++; $display("FAIL halt_clear: got pc=%h halt=%b expected pc=%h halt=0", pc_out, halt, 32'd20);
      end
   endtask

   task automatic test_priority();
      stall_PC = 1'b1; changeFlow = 1'b1; jb_addr = 32'd20;
      switch_program = 1'b1; SPART_pc = 32'd100;
      exp_q.push_back(32'd100);
      tick();
      switch_program = 1'b0;
      exp_pc = exp_q.pop_front();
      vectors++;
      if (pc_out !== exp_pc) begin
         miscompares++; $display("FAIL prio_switch: got %h expected %h", pc_out, exp_pc);
      end
      exp_q.push_back(32'd20);
      tick();
      changeFlow = 1'b0;
      exp_pc = exp_q.pop_front();
      vectors++;
      if (pc_out !== exp_pc) begin
         miscompares++; $display("FAIL prio_redirect: got %h expected %h", pc_out, exp_pc);
      end
      for (int k = 0; k < 2; k++) begin
         exp_q.push_back(32'd20);
         tick();
         exp_pc = exp_q.pop_front();
         vectors++;
         if (pc_out !== exp_pc) begin
            miscompares++; $display("FAIL stall_hold: got %h expected %h", pc_out, exp_pc);
         end
      end
      stall_PC = 1'b0;
      exp_q.push_back(32'd21);
      tick();
      exp_pc = exp_q.pop_front();
      vectors++;
      if (pc_out !== exp_pc) begin
         miscompares++; $display("FAIL stall_release: got %h expected %h", pc_out, exp_pc);
      end
   endtask

   task automatic test_reset_mid();
      mem[5] = br(16'h0003);
      train(32'd5, 1'b1, 2);
      go_to(32'd5);
      vectors++;
      if (pred_taken !== model[5][1]) begin
         miscompares++; $display("FAIL pre_reset_pred: got %b expected %b", pred_taken, model[5][1]);
      end
      @(posedge clk);
      #2 rst = 1'b1;
      #1;
      vectors++;
      if (pc_out !== 32'd0 || pc_1 !== 32'd1) begin
         miscompares++; $display("FAIL async_reset: got pc=%h pc1=%h expected %h %h", pc_out, pc_1, 32'd0, 32'd1);
      end
      @(negedge clk);
      rst = 1'b0;
      for (int k = 0; k < N; k++) model[k] = 2'b01;
      #1;
      go_to(32'd5);
      vectors++;
      if (pred_taken !== model[5][1]) begin
         miscompares++; $display("FAIL reset_ctr5: got %b expected %b", pred_taken, model[5][1]);
      end
      go_to(32'd4);
      vectors++;
      if (pred_taken !== model[4][1]) begin
         miscompares++; $display("FAIL reset_ctr4: got %b expected %b", pred_taken, model[4][1]);
      end
      // One taken step from 01 must reach 10 (distinguishes 01 from 00).
      train(32'd5, 1'b1, 1);
      go_to(32'd5);
      vectors++;
      if (pred_taken !== model[5][1] || pred_addr !== 32'd9) begin
         miscompares++;
         $display("FAIL reset_ctr_step: got pred=%b addr=%h expected pred=%b addr=%h", pred_taken, pred_addr, model[5][1], 32'd9);
      end
   endtask

   initial begin
      for (int k = 0; k < (1 << IMEM_AW); k++) mem[k] = 32'h0;
      for (int k = 0; k < N; k++) model[k] = 2'b01;
      rst = 1'b1;
      stall_PC = 1'b0; changeFlow = 1'b0; jb_addr = '0;
      switch_program = 1'b0; SPART_pc = '0;
      upd_valid = 1'b0; upd_pc = '0; upd_taken = 1'b0;

      test_reset();
      test_sequential();
      test_branch();
      test_saturate();
      test_halt();
      test_priority();
      test_reset_mid();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
`default_nettype wire
